// File: rtl/id_ex_stage.sv
// ---------------------------------------------------------------------------
// id_ex_stage
//
// Decode -> execute pipeline register with a one-entry skid buffer and
// operand forwarding.
//
// A "main" entry drives the ALU-facing outputs. A "skid" entry catches one
// instruction that arrives while main is stalled, so that in_ready can be a
// plain register (no combinational path from out_ready to in_ready).
//
// Ports
//   clk, rst_n                 clock, synchronous active-low reset
//   in_valid / in_ready        decode handshake (in_ready = !skid valid)
//   in_rs, in_rt               source register numbers
//   in_rd_data1, in_rd_data2   register-file read values
//   in_imm, in_use_imm         immediate and operand-2 select
//   in_aluop, in_dest,
//   in_regwrite                control carried with the instruction
//   flush                      discard everything held (taken branch)
//   exmem_*                    forwarding source A (higher priority)
//   memwb_*                    forwarding source B
//   out_valid / out_ready      ALU-side handshake
//   data1, data2, aluoperation,
//   out_dest, out_regwrite     ALU-side payload
//   stall_cnt                  saturating count of out_valid & !out_ready
// ---------------------------------------------------------------------------
module id_ex_stage #(
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [4:0]             in_rs,
  input  logic [4:0]             in_rt,
  input  logic [31:0]            in_rd_data1,
  input  logic [31:0]            in_rd_data2,
  input  logic [31:0]            in_imm,
  input  logic                   in_use_imm,
  input  logic [3:0]             in_aluop,
  input  logic [4:0]             in_dest,
  input  logic                   in_regwrite,
  input  logic                   flush,
  input  logic                   exmem_regwrite,
  input  logic [4:0]             exmem_dest,
  input  logic [31:0]            exmem_result,
  input  logic                   memwb_regwrite,
  input  logic [4:0]             memwb_dest,
  input  logic [31:0]            memwb_result,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [31:0]            data1,
  output logic [31:0]            data2,
  output logic [3:0]             aluoperation,
  output logic [4:0]             out_dest,
  output logic                   out_regwrite,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  typedef struct packed {
    logic        valid;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [31:0] rd_data1;
    logic [31:0] rd_data2;
    logic [31:0] imm;
    logic        use_imm;
    logic [3:0]  aluop;
    logic [4:0]  dest;
    logic        regwrite;
  } entry_t;

  localparam logic [3:0] ALU_ADD = 4'b0010;

  entry_t main_q, main_d;
  entry_t skid_q, skid_d;
  entry_t in_entry;
  logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic accept;
  logic main_free;
  logic stalled;

  always_comb begin
    in_entry.valid    = 1'b1;
    in_entry.rs       = in_rs;
    in_entry.rt       = in_rt;
    in_entry.rd_data1 = in_rd_data1;
    in_entry.rd_data2 = in_rd_data2;
    in_entry.imm      = in_imm;
    in_entry.use_imm  = in_use_imm;
    in_entry.aluop    = in_aluop;
    in_entry.dest     = in_dest;
    in_entry.regwrite = in_regwrite;
  end

  assign in_ready  = !skid_q.valid;
  assign out_valid = main_q.valid;
  assign accept    = in_valid && !skid_q.valid;
  // Main can take a new entry when it is empty or being consumed this cycle.
  assign main_free = !main_q.valid || out_ready;
  assign stalled   = main_q.valid && !out_ready;

  always_comb begin
    main_d = main_q;
    skid_d = skid_q;
    if (flush) begin
      main_d.valid = 1'b0;
      skid_d.valid = 1'b0;
    end else if (main_free) begin
      // A full skid means in_ready is low, so no new input competes with it;
      // the skid entry is always older than anything still upstream.
      if (skid_q.valid) begin
        main_d       = skid_q;
        skid_d.valid = 1'b0;
      end else if (accept) begin
        main_d = in_entry;
      end else begin
        main_d.valid = 1'b0;
      end
    end else if (accept) begin
      skid_d = in_entry;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stalled && !(&stall_cnt_q)) begin
      stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      main_q      <= '0;
      skid_q      <= '0;
      stall_cnt_q <= '0;
    end else begin
      main_q      <= main_d;
      skid_q      <= skid_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;

  // EX/MEM wins over MEM/WB; register 0 is hard-wired and never forwarded.
  function automatic logic [31:0] fwd_value(
    input logic [4:0]  src,
    input logic [31:0] stored,
    input logic        a_we,
    input logic [4:0]  a_dest,
    input logic [31:0] a_val,
    input logic        b_we,
    input logic [4:0]  b_dest,
    input logic [31:0] b_val
  );
    logic [31:0] res;
    res = stored;
    if (src != 5'd0) begin
      if (a_we && (a_dest == src)) begin
        res = a_val;
      end else if (b_we && (b_dest == src)) begin
        res = b_val;
      end
    end
    return res;
  endfunction

  always_comb begin
    data1        = '0;
    data2        = '0;
    aluoperation = ALU_ADD;
    out_dest     = '0;
    out_regwrite = 1'b0;
    if (main_q.valid) begin
      data1 = fwd_value(main_q.rs, main_q.rd_data1,
                        exmem_regwrite, exmem_dest, exmem_result,
                        memwb_regwrite, memwb_dest, memwb_result);
      if (main_q.use_imm) begin
        data2 = main_q.imm;
      end else begin
        data2 = fwd_value(main_q.rt, main_q.rd_data2,
                          exmem_regwrite, exmem_dest, exmem_result,
                          memwb_regwrite, memwb_dest, memwb_result);
      end
      aluoperation = main_q.aluop;
      out_dest     = main_q.dest;
      out_regwrite = main_q.regwrite;
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// ---------------------------------------------------------------------------
// tb_id_ex_stage
//
// Directed bench for id_ex_stage: a table of forwarding vectors plus
// hand-written sequences for streaming, back-pressure, flush, reset and
// stall-counter saturation. Counter width is reduced to 4 bits so that
// saturation is reachable in a few cycles.
// ---------------------------------------------------------------------------
module tb_id_ex_stage;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [4:0]   in_rs, in_rt;
  logic [31:0]  in_rd_data1, in_rd_data2, in_imm;
  logic         in_use_imm;
  logic [3:0]   in_aluop;
  logic [4:0]   in_dest;
  logic         in_regwrite;
  logic         flush;
  logic         exmem_regwrite;
  logic [4:0]   exmem_dest;
  logic [31:0]  exmem_result;
  logic         memwb_regwrite;
  logic [4:0]   memwb_dest;
  logic [31:0]  memwb_result;
  logic         out_valid;
  logic         out_ready;
  logic [31:0]  data1, data2;
  logic [3:0]   aluoperation;
  logic [4:0]   out_dest;
  logic         out_regwrite;
  logic [W-1:0] stall_cnt;

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  id_ex_stage #(.STALL_CNT_W(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs(in_rs), .in_rt(in_rt),
    .in_rd_data1(in_rd_data1), .in_rd_data2(in_rd_data2),
    .in_imm(in_imm), .in_use_imm(in_use_imm),
    .in_aluop(in_aluop), .in_dest(in_dest), .in_regwrite(in_regwrite),
    .flush(flush),
    .exmem_regwrite(exmem_regwrite), .exmem_dest(exmem_dest), .exmem_result(exmem_result),
    .memwb_regwrite(memwb_regwrite), .memwb_dest(memwb_dest), .memwb_result(memwb_result),
    .out_valid(out_valid), .out_ready(out_ready),
    .data1(data1), .data2(data2), .aluoperation(aluoperation),
    .out_dest(out_dest), .out_regwrite(out_regwrite),
    .stall_cnt(stall_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end else begin
      $display("[TB] ok   %s = 0x%08h", name, act);
    end
  endtask

  task automatic set_in(input logic [4:0] rs, input logic [4:0] rt,
                        input logic [31:0] d1, input logic [31:0] d2,
                        input logic [31:0] imm, input logic use_imm,
                        input logic [3:0] op, input logic [4:0] dest);
    in_rs = rs; in_rt = rt; in_rd_data1 = d1; in_rd_data2 = d2;
    in_imm = imm; in_use_imm = use_imm; in_aluop = op;
    in_dest = dest; in_regwrite = 1'b1;
  endtask

  typedef struct {
    string       name;
    logic [4:0]  rs, rt;
    logic [31:0] d1, d2, imm;
    logic        use_imm;
    logic        a_we; logic [4:0] a_dest; logic [31:0] a_val;
    logic        b_we; logic [4:0] b_dest; logic [31:0] b_val;
    logic [31:0] exp_d1, exp_d2;
  } fwd_vec_t;

  fwd_vec_t vecs[7];

  initial begin
    vecs[0] = '{"fwd_exmem_prio", 5, 6, 32'h11, 32'h22, 32'h0, 0, 1, 5, 32'hAA, 1, 5, 32'hBB, 32'hAA, 32'h22};
    vecs[1] = '{"fwd_memwb",      5, 6, 32'h11, 32'h22, 32'h0, 0, 0, 5, 32'hAA, 1, 5, 32'hBB, 32'hBB, 32'h22};
    vecs[2] = '{"fwd_rs_zero",    0, 6, 32'h11, 32'h22, 32'h0, 0, 1, 0, 32'hAA, 1, 0, 32'hBB, 32'h11, 32'h22};
    vecs[3] = '{"imm_no_fwd",     3, 7, 32'h11, 32'h22, 32'hFFFFFFFC, 1, 1, 7, 32'hAA, 1, 7, 32'hBB, 32'h11, 32'hFFFFFFFC};
    vecs[4] = '{"fwd_rt_exmem",   5, 6, 32'h11, 32'h22, 32'h0, 0, 1, 6, 32'hCC, 1, 6, 32'hBB, 32'h11, 32'hCC};
    vecs[5] = '{"fwd_rt_memwb",   4, 9, 32'h11, 32'h22, 32'h0, 0, 0, 9, 32'hAA, 1, 9, 32'hDD, 32'h11, 32'hDD};
    vecs[6] = '{"fwd_rt_zero",    4, 0, 32'h11, 32'h22, 32'h0, 0, 1, 0, 32'hAA, 1, 0, 32'hBB, 32'h11, 32'h22};

    rst_n = 1'b0; in_valid = 1'b1; out_ready = 1'b0; flush = 1'b0;
    set_in(5'd1, 5'd2, 32'h1, 32'h2, 32'h3, 1'b0, 4'b0111, 5'd3);
    exmem_regwrite = 1'b0; exmem_dest = '0; exmem_result = '0;
    memwb_regwrite = 1'b0; memwb_dest = '0; memwb_result = '0;

    // Reset with in_valid high: nothing may be captured.
    tick(); tick();
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_stall_cnt", 32'(stall_cnt), 32'd0);
    check("rst_aluop", 32'(aluoperation), 32'h2);
    check("rst_data1", data1, 32'd0);
    check("rst_data2", data2, 32'd0);
    check("rst_dest", 32'(out_dest), 32'd0);
    check("rst_regwrite", 32'(out_regwrite), 32'd0);

    // Stream of four with out_ready high: one-cycle latency, order kept.
    rst_n = 1'b1; out_ready = 1'b1;
    begin
      logic [3:0] ops [4];
      ops[0] = 4'b0010; ops[1] = 4'b0110; ops[2] = 4'b0000; ops[3] = 4'b0111;
      for (int i = 0; i < 4; i++) begin
        set_in(5'd1, 5'd2, 32'h0, 32'h0, 32'h0, 1'b0, ops[i], 5'(i + 10));
        in_valid = 1'b1;
        tick();
        check($sformatf("stream%0d_valid", i), 32'(out_valid), 32'd1);
        check($sformatf("stream%0d_aluop", i), 32'(aluoperation), 32'(ops[i]));
        check($sformatf("stream%0d_dest", i), 32'(out_dest), 32'(i + 10));
      end
    end
    in_valid = 1'b0;
    tick();
    check("stream_end_valid", 32'(out_valid), 32'd0);
    check("stream_end_aluop", 32'(aluoperation), 32'h2);

    // Back-pressure: A into main, B into skid, C waits upstream.
    out_ready = 1'b0;
    set_in(5'd1, 5'd2, 32'h0, 32'h0, 32'h0, 1'b0, 4'h1, 5'd1); in_valid = 1'b1;
    tick();
    check("bp_a_main", 32'(aluoperation), 32'h1);
    set_in(5'd1, 5'd2, 32'h0, 32'h0, 32'h0, 1'b0, 4'h4, 5'd2);
    tick();
    check("bp_in_ready_low", 32'(in_ready), 32'd0);
    check("bp_a_held", 32'(aluoperation), 32'h1);
    set_in(5'd1, 5'd2, 32'h0, 32'h0, 32'h0, 1'b0, 4'h8, 5'd3);
    tick(); tick();
    check("bp_stall_cnt", 32'(stall_cnt), 32'd3);
    check("bp_a_still_held", 32'(aluoperation), 32'h1);
    out_ready = 1'b1;
    tick();
    check("bp_b_out", 32'(aluoperation), 32'h4);
    check("bp_in_ready_back", 32'(in_ready), 32'd1);
    tick();
    check("bp_c_out", 32'(aluoperation), 32'h8);
    check("bp_c_valid", 32'(out_valid), 32'd1);
    in_valid = 1'b0;
    tick();
    check("bp_drained", 32'(out_valid), 32'd0);
    check("bp_stall_kept", 32'(stall_cnt), 32'd3);

    // Forwarding vectors: load one instruction, hold it, compare operands.
    for (int i = 0; i < 7; i++) begin
      out_ready = 1'b0;
      exmem_regwrite = vecs[i].a_we; exmem_dest = vecs[i].a_dest; exmem_result = vecs[i].a_val;
      memwb_regwrite = vecs[i].b_we; memwb_dest = vecs[i].b_dest; memwb_result = vecs[i].b_val;
      set_in(vecs[i].rs, vecs[i].rt, vecs[i].d1, vecs[i].d2, vecs[i].imm,
             vecs[i].use_imm, 4'h3, 5'd4);
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      check({vecs[i].name, "_d1"}, data1, vecs[i].exp_d1);
      check({vecs[i].name, "_d2"}, data2, vecs[i].exp_d2);
      out_ready = 1'b1;
      tick();
    end
    exmem_regwrite = 1'b0; memwb_regwrite = 1'b0;
    check("fwd_stall_unchanged", 32'(stall_cnt), 32'd3);

    // Flush with main and skid full and a third offer in the same cycle.
    out_ready = 1'b0;
    set_in(5'd1, 5'd2, 32'h0, 32'h0, 32'h0, 1'b0, 4'h3, 5'd1); in_valid = 1'b1;
    tick();
    set_in(5'd1, 5'd2, 32'h0, 32'h0, 32'h0, 1'b0, 4'h5, 5'd2);
    tick();
    check("fl_skid_full", 32'(in_ready), 32'd0);
    set_in(5'd1, 5'd2, 32'h0, 32'h0, 32'h0, 1'b0, 4'h9, 5'd3);
    flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    check("fl_out_valid", 32'(out_valid), 32'd0);
    check("fl_in_ready", 32'(in_ready), 32'd1);
    check("fl_aluop", 32'(aluoperation), 32'h2);
    check("fl_stall_kept", 32'(stall_cnt), 32'd5);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("fl_nothing_emitted%0d", i), 32'(out_valid), 32'd0);
    end

    // Stall up to 7, then push into saturation, then reset while stalled.
    out_ready = 1'b0;
    set_in(5'd1, 5'd2, 32'h0, 32'h0, 32'h0, 1'b0, 4'h6, 5'd1); in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    check("sc_reach7", 32'(stall_cnt), 32'd7);
    for (int i = 0; i < 10; i++) tick();
    check("sc_saturate", 32'(stall_cnt), 32'd15);
    check("sc_held_valid", 32'(out_valid), 32'd1);

    rst_n = 1'b0; in_valid = 1'b1;
    tick();
    check("rs_out_valid", 32'(out_valid), 32'd0);
    check("rs_stall_cnt", 32'(stall_cnt), 32'd0);
    check("rs_aluop", 32'(aluoperation), 32'h2);
    check("rs_in_ready", 32'(in_ready), 32'd1);

    // First edge with reset released must already accept.
    rst_n = 1'b1; out_ready = 1'b1;
    set_in(5'd1, 5'd2, 32'h0, 32'h0, 32'h0, 1'b0, 4'h5, 5'd7); in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("first_xfer_valid", 32'(out_valid), 32'd1);
    check("first_xfer_aluop", 32'(aluoperation), 32'h5);
    tick();
    check("first_xfer_done", 32'(out_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
